// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial add (LSB first) through one full-adder slice with
//                registered carry; optional subtract mode via SERIAL_ADDER_SUB_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_shift;

    assign w_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign w_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        cnt_d       = cnt_q;
        w_sum_shift = sum_q >> 1;
        w_sum_shift[WIDTH-1] = w_s;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
`ifdef SERIAL_ADDER_SUB_EN
                    // a - b computed as a + ~b + 1; carry out means no borrow
                    if (sub) begin
                        b_sr_d  = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = w_sum_shift;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = w_c;
                cnt_d   = cnt_q + 1'b1;
                // c_out gets its own register so it stays put while the next op runs
                if (cnt_q == C_LAST) begin
                    c_out_d = w_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : directed-vector scoreboard bench for serial_adder (WIDTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency on out_valid rise, result on each output handshake
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("latency", cyc - acc_q.pop_front(), WIDTH);
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {23'd0, c_out, sum}, 32'hDEAD);
            end else begin
                check("result", {23'd0, c_out, sum}, {23'd0, exp_q.pop_front()});
            end
        end
        prev_ov = out_valid;
    end

    int last_acc = 0;

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic tsub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic track);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub = tsub;
`endif
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            last_acc = cyc;
            if (track) begin
                exp_q.push_back({ec, es});
                acc_q.push_back(cyc);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            check("in_ready_busy", {31'd0, in_ready}, 0);
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("done_timeout", 0, 1);
    endtask

    int acc1;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_c_out", {31'd0, c_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 1);

        // 1: zero operands
        issue(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_done();
        // 2: full carry ripple
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_done();
        // 3: back-to-back with issue-interval check
        issue(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        acc1 = last_acc;
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);
        check("issue_interval_ge10", {31'd0, (last_acc - acc1) >= 10}, 1);
        wait_done();
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        wait_done();

        // 4: backpressure, in_valid ignored in DONE
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2) begin
                a = 8'h77; b = 8'h00; c_in = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_sum", {24'd0, sum}, 32'h01);
            check("bp_c_out", {31'd0, c_out}, 1);
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", {31'd0, out_valid}, 0);
        check("bp_release_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        check("bp_77_not_consumed", {31'd0, busy}, 0);

        // 5: reset during 4th RUN cycle
        issue(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 0);
        check("abort_sum", {24'd0, sum}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 1);
        repeat (12) @(negedge clk);
        issue(8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1);
        wait_done();

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtract mode (c_in deliberately set to show it is ignored)
        issue(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1);
        wait_done();
        issue(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        wait_done();
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder stage built around the team's full-adder cell.
- Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake.
- Feeds them LSB-first, one bit per clock, through a single full-adder slice with a registered carry.
- Presents the WIDTH-bit sum and carry-out on a valid/ready output handshake to the downstream consumer.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b and c_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  initial carry-in.
- out_valid  output  1  sum and c_out are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, a+b+c_in mod 2^WIDTH.
- c_out  output  1  final carry.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, sum=0, c_out=0, busy=0, internal bit counter=0.
- in_ready is combinational: (state==IDLE) and not rst.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge:
    - latch a and b into right-shift registers A_sr and B_sr;
    - carry register <= c_in;
    - counter <= 0;
    - go to RUN.
  - RUN: each edge:
    - s = A_sr[0]^B_sr[0]^carry;
    - c = (A_sr[0]&B_sr[0]) | (carry&(A_sr[0]^B_sr[0]));
    - sum shifts right with s entering at bit WIDTH-1;
    - A_sr and B_sr shift right;
    - carry <= c; counter++.
    - When counter==WIDTH-1, that edge moves state to DONE.
  - DONE: out_valid=1; sum and c_out=carry are held stable. On out_valid&out_ready at an edge, go to IDLE; out_valid=0 from the next cycle.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Minimum issue interval: WIDTH+2 cycles (RUN, DONE, IDLE).
- Arithmetic: unsigned; sum equals the low WIDTH bits of a+b+c_in; c_out is bit WIDTH of that sum.
- in_valid in RUN or DONE: ignored; a, b and c_in are not sampled; no queuing.
- out_ready outside DONE: ignored.
- Backpressure: DONE is held indefinitely while out_ready=0, with no change to sum or c_out.
- sum register: changes only in RUN. Between operations it retains the last result. Reset is the only thing that clears it.
- WIDTH=1: single RUN cycle; same rules apply.
- Reset mid-operation (RUN or DONE): abort immediately and return to the reset values. The partial result is never presented; out_valid never rises for that operation.
- rst together with in_valid: reset wins; the operands are not accepted.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - adds input port sub (1 bit), sampled together with a and b on acceptance;
  - sub=1: B_sr is loaded with ~b and carry is initialised to 1 (c_in ignored);
  - result: sum = a-b mod 2^WIDTH, and c_out=1 iff a>=b (no borrow);
  - sub=0: behaves as the adder.
- When not defined: no sub port; pure adder exactly as described in Behaviour.

Test Plan:
1. Reset, then a=8'h00, b=8'h00, c_in=0 -> sum=8'h00, c_out=0; out_valid rises exactly 8 edges after the accept edge; in_ready=0 throughout.
2. a=8'hFF, b=8'h01, c_in=0 (carry ripples through all bits) -> sum=8'h00, c_out=1.
3. a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1. Follow with a=8'h12, b=8'h34, c_in=0 -> sum=8'h46, c_out=0, accepted no earlier than 10 cycles after the first accept.
4. Hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with a=8'h77 -> sum and c_out stable, in_ready=0, 8'h77 never consumed. Raise out_ready -> out_valid falls next cycle and in_ready rises.
5. Assert rst on the 4th RUN cycle -> out_valid stays 0, and in_ready=1 in the first cycle after rst drops. Then a=8'h3C, b=8'h42 -> sum=8'h7E, c_out=0.
6. With SERIAL_ADDER_SUB_EN defined:
   - a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, c_out=1;
   - a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, c_out=0.
